snake_key_ctrl: RTL and testbench

Input-conditioning stage that sits directly upstream of the snake game core, between the four raw push-button pins and the movement/state logic. It synchronises and debounces `key_up`, `key_down`, `key_left` and `key_right`, then turns presses into single-cycle events. It maintains the run/idle game state and commits a new heading once per snake move tick, rejecting 180° reversals.

---
 rtl/snake_key_ctrl_if.sv | 27 ++
 rtl/snake_key_ctrl.sv | 166 ++++++++++++++++
 tb/tb_snake_key_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/snake_key_ctrl_if.sv
// snake_key_ctrl_if
//   Bundles the signals between the raw buttons / game core and the key
//   controller.
//   slave  : the key controller (takes keys and core pulses, drives events/state)
//   master : the game core / button side (drives keys and pulses, reads state)
interface snake_key_ctrl_if;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       move_tick;
    logic       game_over;
    logic [3:0] key_press;
    logic       start;
    logic       running;
    logic [1:0] dir;

    modport slave (
        input  key_up, key_down, key_left, key_right, move_tick, game_over,
        output key_press, start, running, dir
    );

    modport master (
        output key_up, key_down, key_left, key_right, move_tick, game_over,
        input  key_press, start, running, dir
    );
endinterface

// File: rtl/snake_key_ctrl.sv
// snake_key_db
//   One button channel: 2-FF synchroniser, debounce counter, rising-edge
//   detect. rise is a decode of flops only, so it is glitch-free.
//   clk, rstn : clock, async active-low reset
//   key_raw   : raw asynchronous button level
//   rise      : high for one cycle when the debounced level goes 0 -> 1
module snake_key_db #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_raw,
    output logic rise
);
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // held different long enough: accept the new level
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise = db_q & ~db_dly_q;
endmodule

// snake_key_ctrl
//   Conditions the four snake buttons into press events and keeps the
//   run/idle state plus the committed heading.
//   clk, rstn : clock, async active-low reset
//   bus       : slave side of snake_key_ctrl_if
//               in : key_up/down/left/right, move_tick, game_over
//               out: key_press {up,down,left,right}, start, running,
//                    dir (00 up, 01 down, 10 left, 11 right)
module snake_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 24
) (
    input  logic              clk,
    input  logic              rstn,
    snake_key_ctrl_if.slave   bus
);
    localparam int          NUM_KEYS = 4;
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_RUN    = 1'b1;
    localparam logic [1:0]  DIR_UP   = 2'b00;
    localparam logic [1:0]  DIR_DOWN = 2'b01;
    localparam logic [1:0]  DIR_LEFT = 2'b10;
    localparam logic [1:0]  DIR_RIGHT= 2'b11;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] rise;

    assign key_raw = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        snake_key_db #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk     (clk),
            .rstn    (rstn),
            .key_raw (key_raw[i]),
            .rise    (rise[i])
        );
    end

    logic [0:0]          state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [1:0]          pend_q, pend_d;
    logic                start_q, start_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [1:0]          win;
    logic                any_evt;

    // fixed priority up > down > left > right
    always_comb begin
        any_evt = |rise;
        if (rise[3])      win = DIR_UP;
        else if (rise[2]) win = DIR_DOWN;
        else if (rise[1]) win = DIR_LEFT;
        else              win = DIR_RIGHT;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        start_d     = 1'b0;
        key_press_d = rise;
        case (state_q)
            S_IDLE: begin
                if (any_evt) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                    pend_d  = win;
                end
            end
            default: begin
                if (bus.game_over) begin
                    // game_over beats a coincident tick; park heading right
                    state_d = S_IDLE;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                end else begin
                    if (bus.move_tick) dir_d = pend_q;
                    // opposite heading differs only in bit 0; checked
                    // against committed dir so two quick turns cannot reverse
                    if (any_evt && (win != (dir_q ^ 2'b01))) pend_d = win;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            start_q     <= 1'b0;
            key_press_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            start_q     <= start_d;
            key_press_q <= key_press_d;
        end
    end

    assign bus.key_press = key_press_q;
    assign bus.start     = start_q;
    assign bus.running   = (state_q == S_RUN);
    assign bus.dir       = dir_q;
endmodule

// File: tb/tb_snake_key_ctrl.sv
// Directed bench for snake_key_ctrl with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_snake_key_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    snake_key_ctrl_if bus ();

    snake_key_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        bus.key_up    = k[3];
        bus.key_down  = k[2];
        bus.key_left  = k[1];
        bus.key_right = k[0];
    endtask

    // hold long enough for one event, release and let the release settle
    task automatic tap(input logic [3:0] k);
        set_keys(k);
        step(8);
        set_keys(4'b0000);
        step(8);
    endtask

    task automatic tick_move();
        bus.move_tick = 1'b1;
        step(1);
        bus.move_tick = 1'b0;
    endtask

    task automatic end_game();
        bus.game_over = 1'b1;
        step(1);
        bus.game_over = 1'b0;
    endtask

    initial begin
        logic found;
        set_keys(4'b0000);
        bus.move_tick = 1'b0;
        bus.game_over = 1'b0;

        // reset and idle
        step(2);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_dir", bus.dir, 2'b11);
            chk("idle_run", bus.running, 1'b0);
            chk("idle_kp", bus.key_press, 4'b0000);
            chk("idle_start", bus.start, 1'b0);
        end

        // 3-cycle glitch on up: no event
        set_keys(4'b1000);
        step(3);
        set_keys(4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_kp", bus.key_press, 4'b0000);
            chk("glitch_run", bus.running, 1'b0);
        end

        // held up: event on the 7th sampled edge (2 sync + 4 count + 1 detect)
        set_keys(4'b1000);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk("hold_kp", bus.key_press, (i == 7) ? 4'b1000 : 4'b0000);
            chk("hold_start", bus.start, (i == 7) ? 1'b1 : 1'b0);
            chk("hold_run", bus.running, (i >= 7) ? 1'b1 : 1'b0);
        end
        set_keys(4'b0000);
        step(10);
        chk("hold_dir_untouched", bus.dir, 2'b11);

        end_game();
        chk("go1_run", bus.running, 1'b0);
        chk("go1_dir", bus.dir, 2'b11);

        // reversal rejection from dir=11
        tap(4'b0001);
        chk("rev_run", bus.running, 1'b1);
        tick_move();
        chk("rev_dir_init", bus.dir, 2'b11);
        tap(4'b0010);
        tick_move();
        chk("rev_left_rejected", bus.dir, 2'b11);
        tap(4'b1000);
        chk("rev_no_tick_yet", bus.dir, 2'b11);
        tick_move();
        chk("rev_up_taken", bus.dir, 2'b00);

        // double turn: right then down, down rejected vs committed up
        tap(4'b0001);
        tap(4'b0100);
        chk("dbl_before_tick", bus.dir, 2'b00);
        tick_move();
        chk("dbl_dir", bus.dir, 2'b11);

        end_game();
        chk("go2_run", bus.running, 1'b0);

        // simultaneous up+left in IDLE
        set_keys(4'b1010);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (!found && bus.key_press != 4'b0000) begin
                found = 1'b1;
                chk("sim_kp", bus.key_press, 4'b1010);
                chk("sim_start", bus.start, 1'b1);
            end
        end
        chk("sim_seen", found, 1'b1);
        set_keys(4'b0000);
        step(10);
        tick_move();
        chk("sim_dir", bus.dir, 2'b00);

        // game_over with coincident tick and a pending left
        tap(4'b0010);
        bus.game_over = 1'b1;
        bus.move_tick = 1'b1;
        step(1);
        bus.game_over = 1'b0;
        bus.move_tick = 1'b0;
        chk("gotick_run", bus.running, 1'b0);
        chk("gotick_dir", bus.dir, 2'b11);
        tick_move();
        chk("idle_tick_dir", bus.dir, 2'b11);
        chk("idle_tick_run", bus.running, 1'b0);

        // reset mid-debounce, then a short press
        set_keys(4'b1000);
        step(4);
        rstn = 1'b0;
        set_keys(4'b0000);
        step(1);
        chk("rst_kp", bus.key_press, 4'b0000);
        rstn = 1'b1;
        step(1);
        set_keys(4'b1000);
        step(3);
        set_keys(4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("rst_short_kp", bus.key_press, 4'b0000);
            chk("rst_short_run", bus.running, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
